load_extend_pipe: RTL and testbench

- Pipelined load-data extraction and extension unit for the memory/writeback boundary.
- Takes a full-width memory read word, selects the addressed byte, halfword or word lane, and zero- or sign-extends it to DATA_WIDTH.
- Registers the result behind a valid/ready handshake with a one-entry skid buffer, so writeback stalls never drop or reorder loads.

---
 rtl/load_extend_pipe.sv | 177 +++++++++++++++++
 tb/tb_load_extend_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_extend_pipe.sv
// load_extend_pipe
//   Pipelined load-data extraction and extension unit. Selects the addressed
//   byte / halfword / word / doubleword lane from a full-width memory read
//   word, zero- or sign-extends it to DATA_WIDTH, and registers the result
//   behind a valid/ready handshake with a one-entry skid buffer.
//
// Parameters:
//   DATA_WIDTH  datapath width in bits (32 or 64)
//   BIG_ENDIAN  1: byte offset 0 is the most significant byte of InData
//
// Ports:
//   Clock     rising-edge clock
//   nReset    synchronous active-low reset
//   InValid   upstream presents a load word this cycle
//   InReady   unit can accept an input (registered state only)
//   InData    raw aligned memory read word
//   ByteAddr  byte offset of the access within InData
//   Size      00 byte, 01 halfword, 10 word, 11 doubleword
//   Unsgnsel  1 zero-extend, 0 sign-extend
//   OutValid  Out holds a valid result
//   OutReady  downstream accepts Out this cycle
//   Out       extracted and extended load value
//   AddrErr   (only with LOAD_EXTEND_MISALIGN_EN) misaligned access flag
//
// Build option:
//   LOAD_EXTEND_MISALIGN_EN  adds AddrErr, carried alongside each result.

module load_extend_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                              Clock,
  input  logic                              nReset,
  input  logic                              InValid,
  output logic                              InReady,
  input  logic [DATA_WIDTH-1:0]             InData,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   ByteAddr,
  input  logic [1:0]                        Size,
  input  logic                              Unsgnsel,
  output logic                              OutValid,
  input  logic                              OutReady,
`ifdef LOAD_EXTEND_MISALIGN_EN
  output logic [DATA_WIDTH-1:0]             Out,
  output logic                              AddrErr
`else
  output logic [DATA_WIDTH-1:0]             Out
`endif
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(NB);

  logic [AW:0]           wbytes;
  logic [AW-1:0]         lane_mask;
  logic [AW-1:0]         eoff;
  logic [AW:0]           shift_bytes;
  logic [AW+3:0]         wbits;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] field_mask;
  logic [DATA_WIDTH-1:0] msb_mask;
  logic                  sign;
  logic [DATA_WIDTH-1:0] result;
  logic                  accept;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  // Lane extraction and extension
  always_comb begin
    case (Size)
      2'b00:   wbytes = (AW+1)'(1);
      2'b01:   wbytes = (AW+1)'(2);
      2'b10:   wbytes = (AW+1)'(4);
      default: wbytes = (DATA_WIDTH == 64) ? (AW+1)'(8) : (AW+1)'(4);
    endcase
    // A full-width access truncates to zero here, and zero-minus-one gives
    // an all-ones lane mask, which is what force-alignment needs.
    lane_mask = AW'(wbytes - (AW+1)'(1));
    eoff      = ByteAddr & ~lane_mask;
    if (BIG_ENDIAN)
      shift_bytes = (AW+1)'(NB) - {1'b0, eoff} - wbytes;
    else
      shift_bytes = {1'b0, eoff};
    shifted    = InData >> {shift_bytes, 3'b000};
    wbits      = {wbytes, 3'b000};
    // Shifting by the full width yields zero, so W == DATA_WIDTH gives an
    // all-ones mask and the word passes through unchanged.
    field_mask = ~({DATA_WIDTH{1'b1}} << wbits);
    msb_mask   = field_mask ^ (field_mask >> 1);
    sign       = |(shifted & msb_mask);
    result     = (shifted & field_mask) |
                 ((!Unsgnsel && sign) ? ~field_mask : {DATA_WIDTH{1'b0}});
  end

  // The skid register is the only thing that can refuse an input, so
  // InReady never depends combinationally on OutReady.
  assign InReady = !skid_valid_q;
  assign accept  = InValid && InReady;

  // Output/skid next state: drain skid first to preserve accept order
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || OutReady) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = accept;
        if (accept) skid_data_d = result;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = result;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = result;
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign OutValid = out_valid_q;
  assign Out      = out_data_q;

`ifdef LOAD_EXTEND_MISALIGN_EN
  logic err_in;
  logic out_err_q, out_err_d;
  logic skid_err_q, skid_err_d;

  // The flag follows exactly the same path as its data word.
  assign err_in = |(ByteAddr & lane_mask);

  always_comb begin
    out_err_d  = out_err_q;
    skid_err_d = skid_err_q;
    if (!out_valid_q || OutReady) begin
      if (skid_valid_q) begin
        out_err_d = skid_err_q;
        if (accept) skid_err_d = err_in;
      end else if (accept) begin
        out_err_d = err_in;
      end
    end else if (accept) begin
      skid_err_d = err_in;
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      out_err_q  <= 1'b0;
      skid_err_q <= 1'b0;
    end else begin
      out_err_q  <= out_err_d;
      skid_err_q <= skid_err_d;
    end
  end

  assign AddrErr = out_err_q;
`endif

endmodule

// File: tb/tb_load_extend_pipe.sv
// tb_load_extend_pipe
//   Scoreboard bench for load_extend_pipe. Three instances cover 32-bit
//   big-endian, 32-bit little-endian and 64-bit little-endian builds.
//   Stimulus pushes hand-computed expected results into a per-instance
//   queue; a negedge monitor compares whatever each instance presents.
//   Honours LOAD_EXTEND_MISALIGN_EN for the AddrErr output.

`timescale 1ns/1ps

module tb_load_extend_pipe;

  typedef struct {
    logic [63:0] data;
    logic        err;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        out_ready;
  logic [63:0] in_data;
  logic [2:0]  byte_addr;
  logic [1:0]  size;
  logic        uns;
  logic        v_be, v_le, v_64;

  logic        rdy_be, rdy_le, rdy_64;
  logic        ov_be, ov_le, ov_64;
  logic [31:0] out_be, out_le;
  logic [63:0] out_64;
  logic        err_be, err_le, err_64;

  exp_t q_be[$];
  exp_t q_le[$];
  exp_t q_64[$];

  int checks = 0;
  int errors = 0;

  load_extend_pipe #(.DATA_WIDTH(32), .BIG_ENDIAN(1'b1)) dut_be (
    .Clock(clk), .nReset(rst_n), .InValid(v_be), .InReady(rdy_be),
    .InData(in_data[31:0]), .ByteAddr(byte_addr[1:0]), .Size(size),
    .Unsgnsel(uns), .OutValid(ov_be), .OutReady(out_ready),
`ifdef LOAD_EXTEND_MISALIGN_EN
    .Out(out_be), .AddrErr(err_be)
`else
    .Out(out_be)
`endif
  );

  load_extend_pipe #(.DATA_WIDTH(32), .BIG_ENDIAN(1'b0)) dut_le (
    .Clock(clk), .nReset(rst_n), .InValid(v_le), .InReady(rdy_le),
    .InData(in_data[31:0]), .ByteAddr(byte_addr[1:0]), .Size(size),
    .Unsgnsel(uns), .OutValid(ov_le), .OutReady(out_ready),
`ifdef LOAD_EXTEND_MISALIGN_EN
    .Out(out_le), .AddrErr(err_le)
`else
    .Out(out_le)
`endif
  );

  load_extend_pipe #(.DATA_WIDTH(64), .BIG_ENDIAN(1'b0)) dut_64 (
    .Clock(clk), .nReset(rst_n), .InValid(v_64), .InReady(rdy_64),
    .InData(in_data), .ByteAddr(byte_addr), .Size(size),
    .Unsgnsel(uns), .OutValid(ov_64), .OutReady(out_ready),
`ifdef LOAD_EXTEND_MISALIGN_EN
    .Out(out_64), .AddrErr(err_64)
`else
    .Out(out_64)
`endif
  );

`ifndef LOAD_EXTEND_MISALIGN_EN
  assign err_be = 1'b0;
  assign err_le = 1'b0;
  assign err_64 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Per-instance queue helpers
  function automatic int qSize(input int sel);
    case (sel)
      0:       return q_be.size();
      1:       return q_le.size();
      default: return q_64.size();
    endcase
  endfunction

  function automatic logic dutReady(input int sel);
    case (sel)
      0:       return rdy_be;
      1:       return rdy_le;
      default: return rdy_64;
    endcase
  endfunction

  function automatic logic dutValid(input int sel);
    case (sel)
      0:       return ov_be;
      1:       return ov_le;
      default: return ov_64;
    endcase
  endfunction

  task automatic qPush(input int sel, input exp_t e);
    case (sel)
      0:       q_be.push_back(e);
      1:       q_le.push_back(e);
      default: q_64.push_back(e);
    endcase
  endtask

  task automatic setValid(input int sel, input logic v);
    case (sel)
      0:       v_be = v;
      1:       v_le = v;
      default: v_64 = v;
    endcase
  endtask

  // Drive one load into instance sel, recording its expected result.
  task automatic applyStimulus(input int sel, input logic [63:0] data,
                               input logic [2:0] addr, input logic [1:0] sz,
                               input logic u, input logic [63:0] exp_data,
                               input logic exp_err, input string name);
    int   guard;
    int   qlen;
    exp_t e;
    guard = 0;
    while (!dutReady(sel)) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 20) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s ready timeout got InReady=0 expected 1", name);
        return;
      end
    end
    qlen       = qSize(sel);
    e.data     = exp_data;
    e.err      = exp_err;
    e.name     = name;
    qPush(sel, e);
    in_data    = data;
    byte_addr  = addr;
    size       = sz;
    uns        = u;
    setValid(sel, 1'b1);
    @(posedge clk);
    #1;
    setValid(sel, 1'b0);
    if (out_ready && qlen == 0) begin
      checks++;
      if (dutValid(sel) !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s latency got OutValid=%b expected 1", name, dutValid(sel));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare one instance's presented output against the queue head; pop
  // only when the downstream actually takes it.
  task automatic checkOutput(input int sel, input logic valid,
                             input logic [63:0] got, input logic got_err);
    exp_t e;
    if (!valid) return;
    checks++;
    if (qSize(sel) == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_output dut%0d got %h expected none", sel, got);
      return;
    end
    case (sel)
      0:       e = q_be[0];
      1:       e = q_le[0];
      default: e = q_64[0];
    endcase
`ifdef LOAD_EXTEND_MISALIGN_EN
    if (got !== e.data || got_err !== e.err) begin
      errors++;
      $display("[TB] FAIL %s got %h err=%b expected %h err=%b", e.name, got, got_err, e.data, e.err);
    end
`else
    if (got !== e.data) begin
      errors++;
      $display("[TB] FAIL %s got %h (err %b) expected %h", e.name, got, got_err, e.data);
    end
`endif
    if (out_ready) begin
      case (sel)
        0:       void'(q_be.pop_front());
        1:       void'(q_le.pop_front());
        default: void'(q_64.pop_front());
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput(0, ov_be, {32'h0, out_be}, err_be);
      checkOutput(1, ov_le, {32'h0, out_le}, err_le);
      checkOutput(2, ov_64, out_64, err_64);
    end
  end

  task automatic checkIdle(input string name, input logic ov, input logic [63:0] got, input logic rdy);
    checks++;
    if (ov !== 1'b0 || got !== 64'h0 || rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s got valid=%b out=%h ready=%b expected valid=0 out=0 ready=1",
               name, ov, got, rdy);
    end
  endtask

  initial begin
    int guard;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    byte_addr = '0;
    size      = '0;
    uns       = 1'b0;
    v_be      = 1'b0;
    v_le      = 1'b0;
    v_64      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkIdle("reset_be", ov_be, {32'h0, out_be}, rdy_be);
    checkIdle("reset_le", ov_le, {32'h0, out_le}, rdy_le);
    checkIdle("reset_64", ov_64, out_64, rdy_64);

    // Bytes, big-endian 32-bit
    applyStimulus(0, 64'h80FF7F01, 3'd0, 2'b00, 1'b0, 64'hFFFFFF80, 1'b0, "be_b0_s");      idle(1);
    applyStimulus(0, 64'h80FF7F01, 3'd3, 2'b00, 1'b1, 64'h00000001, 1'b0, "be_b3_u");      idle(1);
    applyStimulus(0, 64'h80FF7F01, 3'd1, 2'b00, 1'b0, 64'hFFFFFFFF, 1'b0, "be_b1_s");      idle(1);
    applyStimulus(0, 64'h80FF7F01, 3'd2, 2'b00, 1'b1, 64'h0000007F, 1'b0, "be_b2_u");      idle(1);
    // Halfwords and words, big-endian 32-bit
    applyStimulus(0, 64'h80017FFE, 3'd0, 2'b01, 1'b0, 64'hFFFF8001, 1'b0, "be_h0_s");      idle(1);
    applyStimulus(0, 64'h80017FFE, 3'd2, 2'b01, 1'b0, 64'h00007FFE, 1'b0, "be_h2_s");      idle(1);
    applyStimulus(0, 64'h80017FFE, 3'd0, 2'b01, 1'b1, 64'h00008001, 1'b0, "be_h0_u");      idle(1);
    applyStimulus(0, 64'h80017FFE, 3'd0, 2'b10, 1'b0, 64'h80017FFE, 1'b0, "be_w0");        idle(1);
    applyStimulus(0, 64'h80017FFE, 3'd0, 2'b11, 1'b1, 64'h80017FFE, 1'b0, "be_d_as_w");    idle(1);
    // Misaligned halfwords force-align; AddrErr reports the offset
    applyStimulus(0, 64'h80017FFE, 3'd1, 2'b01, 1'b0, 64'hFFFF8001, 1'b1, "be_h1_mis");    idle(1);
    applyStimulus(0, 64'h80017FFE, 3'd2, 2'b01, 1'b0, 64'h00007FFE, 1'b0, "be_h2_ok");     idle(1);
    applyStimulus(0, 64'h80017FFE, 3'd3, 2'b01, 1'b1, 64'h00007FFE, 1'b1, "be_h3_mis");    idle(1);

    // Little-endian 32-bit
    applyStimulus(1, 64'h80017FFE, 3'd0, 2'b01, 1'b0, 64'h00007FFE, 1'b0, "le_h0_s");      idle(1);
    applyStimulus(1, 64'h80017FFE, 3'd2, 2'b01, 1'b0, 64'hFFFF8001, 1'b0, "le_h2_s");      idle(1);
    applyStimulus(1, 64'h80FF7F01, 3'd0, 2'b00, 1'b1, 64'h00000001, 1'b0, "le_b0_u");      idle(1);
    applyStimulus(1, 64'h80FF7F01, 3'd3, 2'b00, 1'b0, 64'hFFFFFF80, 1'b0, "le_b3_s");      idle(1);

    // Little-endian 64-bit
    applyStimulus(2, 64'h8000000012345678, 3'd4, 2'b10, 1'b0, 64'hFFFFFFFF80000000, 1'b0, "d64_w4_s"); idle(1);
    applyStimulus(2, 64'h8000000012345678, 3'd0, 2'b11, 1'b0, 64'h8000000012345678, 1'b0, "d64_dw");   idle(1);
    applyStimulus(2, 64'h8000000012345678, 3'd0, 2'b10, 1'b0, 64'h0000000012345678, 1'b0, "d64_w0_s"); idle(1);
    applyStimulus(2, 64'h8000000012345678, 3'd7, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFF80, 1'b0, "d64_b7_s"); idle(1);
    applyStimulus(2, 64'h8000000012345678, 3'd2, 2'b01, 1'b1, 64'h0000000000001234, 1'b0, "d64_h2_u"); idle(1);
    applyStimulus(2, 64'h8000000012345678, 3'd4, 2'b10, 1'b1, 64'h0000000080000000, 1'b0, "d64_w4_u"); idle(1);

    // Stall: output held, second load parks in the skid register
    applyStimulus(0, 64'h80FF7F01, 3'd0, 2'b00, 1'b1, 64'h00000080, 1'b0, "stall_l1");
    out_ready = 1'b0;
    applyStimulus(0, 64'h80FF7F01, 3'd1, 2'b00, 1'b1, 64'h000000FF, 1'b0, "stall_l2");
    checks++;
    if (rdy_be !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_inready got %b expected 0", rdy_be);
    end
    idle(3);
    out_ready = 1'b1;
    applyStimulus(0, 64'h80FF7F01, 3'd2, 2'b00, 1'b1, 64'h0000007F, 1'b0, "stall_l3");
    applyStimulus(0, 64'h80FF7F01, 3'd3, 2'b00, 1'b1, 64'h00000001, 1'b0, "stall_l4");
    idle(4);

    // Reset with both registers occupied discards everything
    out_ready = 1'b0;
    applyStimulus(0, 64'h80017FFE, 3'd0, 2'b01, 1'b0, 64'hFFFF8001, 1'b0, "rst_a");
    applyStimulus(0, 64'h80017FFE, 3'd2, 2'b01, 1'b0, 64'h00007FFE, 1'b0, "rst_b");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_be.delete();
    checkIdle("midstall_reset", ov_be, {32'h0, out_be}, rdy_be);
    out_ready = 1'b1;
    idle(4);
    applyStimulus(0, 64'h80FF7F01, 3'd0, 2'b00, 1'b0, 64'hFFFFFF80, 1'b0, "post_reset");
    idle(2);

    // Everything expected must have come out
    guard = 0;
    while ((q_be.size() + q_le.size() + q_64.size()) != 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    checks++;
    if ((q_be.size() + q_le.size() + q_64.size()) != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending expected 0",
               q_be.size() + q_le.size() + q_64.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
